// File: rtl/sdram_model.sv
// Device-side SDR SDRAM responder: decodes the command pins, tracks mode and
// per-bank open rows, runs read/write bursts against a backing array with a
// CAS-latency read pipeline, and latches the first protocol violation seen.
module sdram_model #(
  parameter int DW     = 16,
  parameter int RAW    = 12,
  parameter int CAW    = 9,
  parameter int MEM_AW = 14
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sdram_cke,
  input  logic            sdram_cs_n,
  input  logic            sdram_ras_n,
  input  logic            sdram_cas_n,
  input  logic            sdram_we_n,
  input  logic [RAW-1:0]  sdram_addr,
  input  logic [1:0]      sdram_ba,
  input  logic [DW/8-1:0] sdram_dqm,
  inout  wire  [DW-1:0]   sdram_dq,
  output logic            err,
  output logic [2:0]      err_code,
  output logic [15:0]     refresh_cnt,
  output logic [RAW-1:0]  mode_reg
);
  localparam int NB = DW/8;

  typedef enum logic [1:0] {B_IDLE, B_READ, B_WRITE} bst_e;

  // Burst-length field to the column wrap mask; single word and reserved give 0.
  function automatic logic [CAW-1:0] bl_mask(input logic [2:0] f);
    case (f)
      3'd1:    return CAW'(1);
      3'd2:    return CAW'(3);
      3'd3:    return CAW'(7);
      3'd7:    return '1;
      default: return '0;
    endcase
  endfunction

  // Reserved burst length or a CAS latency other than 2/3.
  function automatic logic mode_bad(input logic [RAW-1:0] m);
    return (m[2:0] inside {3'd4, 3'd5, 3'd6}) || !(m[6:4] inside {3'd2, 3'd3});
  endfunction

  // Column of word i: the bits under the mask wrap, the rest stay fixed.
  function automatic logic [CAW-1:0] burst_col(input logic [CAW-1:0] c, input logic [CAW-1:0] i,
                                               input logic [CAW-1:0] m, input logic ilv);
    logic [CAW-1:0] lo;
    lo = ilv ? (c ^ i) : (c + i);
    return (c & ~m) | (lo & m);
  endfunction

  function automatic logic [MEM_AW-1:0] mem_idx(input logic [1:0] b, input logic [RAW-1:0] r,
                                                input logic [CAW-1:0] c);
    return MEM_AW'({b, r, c});
  endfunction

  logic [RAW-1:0]      mode_q, mode_d;
  logic [3:0]          open_q, open_d;
  logic [3:0][RAW-1:0] row_q, row_d;
  logic                err_q, err_d;
  logic [2:0]          code_q, code_d;
  logic [15:0]         ref_q, ref_d;
  bst_e                bst_q, bst_d;
  logic [1:0]          bba_q, bba_d;
  logic [RAW-1:0]      brow_q, brow_d;
  logic [CAW-1:0]      bcol_q, bcol_d, bcnt_q, bcnt_d, bmask_q, bmask_d;
  logic                bfull_q, bfull_d, bilv_q, bilv_d, bap_q, bap_d;
  logic [1:0]          vld_pipe_q, vld_pipe_d;
  logic [1:0][DW-1:0]  pdat_q, pdat_d;
  logic [DW-1:0]       out_q, out_d;
  logic [NB-1:0]       oe_q, oe_d, dqm_q, dqm_d;

  logic [DW-1:0]       mem [2**MEM_AW];
  logic                mem_we;
  logic [MEM_AW-1:0]   mem_addr;
  logic [DW-1:0]       mem_rdata;

  logic c_act, c_rd, c_wr, c_pre, c_ref, c_lmr, c_bst;
  logic [2:0]     raise;
  logic [RAW-1:0] cmd_row;
  logic [CAW-1:0] cmd_mask;
  logic           cmd_full, kill, cl2;

  assign mem_rdata = mem[mem_addr];

  // Decode the command pins; with CKE low nothing is seen.
  always_comb begin
    c_act = 1'b0; c_rd = 1'b0; c_wr = 1'b0; c_pre = 1'b0;
    c_ref = 1'b0; c_lmr = 1'b0; c_bst = 1'b0;
    if (sdram_cke && !sdram_cs_n) begin
      case ({sdram_ras_n, sdram_cas_n, sdram_we_n})
        3'b011:  c_act = 1'b1;
        3'b101:  c_rd  = 1'b1;
        3'b100:  c_wr  = 1'b1;
        3'b010:  c_pre = 1'b1;
        3'b001:  c_ref = 1'b1;
        3'b000:  c_lmr = 1'b1;
        3'b110:  c_bst = 1'b1;
        default: ;
      endcase
    end
  end

  // Next state: read pipeline shift, burst step or truncation, then command effects.
  always_comb begin
    mode_d = mode_q; open_d = open_q; row_d = row_q;
    err_d = err_q; code_d = code_q; ref_d = ref_q;
    bst_d = bst_q; bba_d = bba_q; brow_d = brow_q; bcol_d = bcol_q; bcnt_d = bcnt_q;
    bmask_d = bmask_q; bfull_d = bfull_q; bilv_d = bilv_q; bap_d = bap_q;
    vld_pipe_d = vld_pipe_q; pdat_d = pdat_q; out_d = out_q; oe_d = oe_q; dqm_d = dqm_q;
    mem_we   = 1'b0;
    mem_addr = mem_idx(bba_q, brow_q, burst_col(bcol_q, bcnt_q, bmask_q, bilv_q));
    raise    = 3'd0;
    cmd_row  = open_q[sdram_ba] ? row_q[sdram_ba] : '0;
    cmd_mask = bl_mask(mode_q[2:0]);
    cmd_full = (mode_q[2:0] == 3'd7);
    if (c_wr && mode_q[9]) begin
      cmd_mask = '0;
      cmd_full = 1'b0;
    end
    kill = c_rd | c_wr | c_bst | (c_pre & (sdram_addr[10] | (sdram_ba == bba_q)));
    cl2  = (mode_q[6:4] == 3'd2);

    if (sdram_cke) begin
      // Read DQM acts on the word driven one edge after it was sampled.
      dqm_d = sdram_dqm;
      out_d = cl2 ? pdat_q[0] : pdat_q[1];
      oe_d  = {NB{cl2 ? vld_pipe_q[0] : vld_pipe_q[1]}} & ~dqm_q;
      pdat_d[1]     = pdat_q[0];
      vld_pipe_d[1] = vld_pipe_q[0];
      pdat_d[0]     = mem_rdata;
      vld_pipe_d[0] = 1'b0;

      if (bst_q != B_IDLE) begin
        if (kill) begin
          bst_d = B_IDLE;
          if (bap_q) open_d[bba_q] = 1'b0;
        end else begin
          if (bst_q == B_READ) vld_pipe_d[0] = 1'b1;
          else                 mem_we = 1'b1;
          bcnt_d = bcnt_q + 1'b1;
          if (!bfull_q && bcnt_q == bmask_q) begin
            bst_d = B_IDLE;
            if (bap_q) open_d[bba_q] = 1'b0;
          end
        end
      end

      if (c_rd || c_wr) begin
        if (!open_q[sdram_ba]) raise = 3'd1;
        mem_addr = mem_idx(sdram_ba, cmd_row, sdram_addr[CAW-1:0]);
        if (c_rd) begin
          vld_pipe_d[0] = 1'b1;
        end else begin
          // A write drops every read word that has not reached the pins yet.
          mem_we     = 1'b1;
          vld_pipe_d = 2'b00;
          oe_d       = '0;
        end
        bba_d   = sdram_ba;
        brow_d  = cmd_row;
        bcol_d  = sdram_addr[CAW-1:0];
        bmask_d = cmd_mask;
        bfull_d = cmd_full;
        bilv_d  = mode_q[3] & ~cmd_full;
        bap_d   = sdram_addr[10];
        bcnt_d  = CAW'(1);
        bst_d   = (cmd_full || cmd_mask != '0) ? (c_rd ? B_READ : B_WRITE) : B_IDLE;
        if (bst_d == B_IDLE && sdram_addr[10]) open_d[sdram_ba] = 1'b0;
      end

      if (c_act) begin
        if (open_q[sdram_ba]) raise = 3'd2;
        open_d[sdram_ba] = 1'b1;
        row_d[sdram_ba]  = sdram_addr;
      end
      if (c_pre) begin
        if (sdram_addr[10]) open_d = '0;
        else                open_d[sdram_ba] = 1'b0;
      end
      if (c_ref) begin
        if (|open_q) raise = 3'd3;
        ref_d = ref_q + 16'd1;
      end
      if (c_lmr) begin
        if (|open_q)                     raise = 3'd4;
        else if (mode_bad(sdram_addr)) raise = 3'd5;
        mode_d = sdram_addr;
      end
      if (raise != 3'd0 && !err_q) begin
        err_d  = 1'b1;
        code_d = raise;
      end
    end
  end

  // State registers; reset closes banks, restores mode and releases the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= RAW'(48); open_q <= '0; row_q <= '0;
      err_q <= 1'b0; code_q <= '0; ref_q <= '0;
      bst_q <= B_IDLE; bba_q <= '0; brow_q <= '0; bcol_q <= '0; bcnt_q <= '0;
      bmask_q <= '0; bfull_q <= 1'b0; bilv_q <= 1'b0; bap_q <= 1'b0;
      vld_pipe_q <= '0; pdat_q <= '0; out_q <= '0; oe_q <= '0; dqm_q <= '0;
    end else begin
      mode_q <= mode_d; open_q <= open_d; row_q <= row_d;
      err_q <= err_d; code_q <= code_d; ref_q <= ref_d;
      bst_q <= bst_d; bba_q <= bba_d; brow_q <= brow_d; bcol_q <= bcol_d; bcnt_q <= bcnt_d;
      bmask_q <= bmask_d; bfull_q <= bfull_d; bilv_q <= bilv_d; bap_q <= bap_d;
      vld_pipe_q <= vld_pipe_d; pdat_q <= pdat_d; out_q <= out_d; oe_q <= oe_d; dqm_q <= dqm_d;
    end
  end

  // Backing array: byte-masked write, contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int b = 0; b < NB; b++) begin
        if (!sdram_dqm[b]) mem[mem_addr][b*8 +: 8] <= sdram_dq[b*8 +: 8];
      end
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_lane
    assign sdram_dq[b*8 +: 8] = oe_q[b] ? out_q[b*8 +: 8] : 8'bz;
  end

  assign err         = err_q;
  assign err_code    = code_q;
  assign refresh_cnt = ref_q;
  assign mode_reg    = mode_q;
endmodule

// File: tb/tb_sdram_model.sv
// Directed bench for sdram_model; released dq lanes read back as 1 via the pull on the bus.
module tb_sdram_model;
  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010, REF = 4'b0001, LMR = 4'b0000, BST = 4'b0110;

  logic        clk = 1'b0, rst = 1'b1, cke = 1'b1;
  logic        cs_n = 1'b0, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic [11:0] addr = '0;
  logic [1:0]  ba = '0, dqm = '0;
  logic        tb_drv = 1'b0;
  logic [15:0] tb_dat = '0;
  tri1  [15:0] dq;
  logic        err;
  logic [2:0]  err_code;
  logic [15:0] refresh_cnt;
  logic [11:0] mode_reg;
  int          n_chk = 0, n_fail = 0;
  int          ilv[8] = '{5, 4, 7, 6, 1, 0, 3, 2};

  assign dq = tb_drv ? tb_dat : 16'bz;
  always #5 clk = ~clk;

  sdram_model #(.DW(16), .RAW(12), .CAW(9), .MEM_AW(14)) dut (
    .clk(clk), .rst(rst), .sdram_cke(cke), .sdram_cs_n(cs_n), .sdram_ras_n(ras_n),
    .sdram_cas_n(cas_n), .sdram_we_n(we_n), .sdram_addr(addr), .sdram_ba(ba),
    .sdram_dqm(dqm), .sdram_dq(dq), .err(err), .err_code(err_code),
    .refresh_cnt(refresh_cnt), .mode_reg(mode_reg)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [3:0] c, input logic [1:0] b, input logic [11:0] a);
    {cs_n, ras_n, cas_n, we_n} = c;
    ba = b;
    addr = a;
    step();
    {cs_n, ras_n, cas_n, we_n} = NOP;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    step(); step();
    chk("rst_err", 16'(err), 16'h0);
    chk("rst_code", 16'(err_code), 16'h0);
    chk("rst_ref", refresh_cnt, 16'h0);
    chk("rst_mode", 16'(mode_reg), 16'h030);
    chk("rst_dq", dq, 16'hFFFF);
    rst = 1'b0;
    step();

    // CL2 BL4 sequential write then read from column 6
    cmd(LMR, 0, 12'h022);
    chk("lmr", 16'(mode_reg), 16'h022);
    cmd(ACT, 1, 12'h055);
    tb_drv = 1'b1; tb_dat = 16'h00A0;
    cmd(WR, 1, 12'h006);
    for (int i = 1; i < 4; i++) begin tb_dat = 16'(16'h00A0 + i); step(); end
    tb_drv = 1'b0;
    cmd(RD, 1, 12'h006);
    for (int i = 0; i < 4; i++) begin step(); chk("bl4_rd", dq, 16'(16'h00A0 + i)); end
    step();
    chk("bl4_end", dq, 16'hFFFF);

    // BL1 reads expose where the wrapped burst landed (cols 4 and 7), back to back
    cmd(PRE, 0, 12'h400);
    cmd(LMR, 0, 12'h020);
    cmd(ACT, 1, 12'h055);
    cmd(RD, 1, 12'h004);
    cmd(RD, 1, 12'h007);
    chk("bl1_c4", dq, 16'h00A2);
    step();
    chk("bl1_c7", dq, 16'h00A1);
    step();

    // Fill cols 0..7, then interleaved BL8 CL3 read from col 5 with a CKE stall
    for (int c = 0; c < 8; c++) begin
      tb_drv = 1'b1; tb_dat = 16'(16'h0C00 + c);
      cmd(WR, 1, 12'(c));
    end
    tb_drv = 1'b0;
    cmd(PRE, 0, 12'h400);
    cmd(LMR, 0, 12'h03B);
    cmd(ACT, 1, 12'h055);
    cmd(RD, 1, 12'h005);
    step();
    chk("cl3_early", dq, 16'hFFFF);
    step();
    chk("ilv_w0", dq, 16'(16'h0C00 + ilv[0]));
    for (int i = 1; i < 8; i++) begin
      if (i == 3) begin
        cke = 1'b0; step(); cke = 1'b1;
        chk("cke_hold", dq, 16'(16'h0C00 + ilv[2]));
      end
      step();
      chk("ilv_rd", dq, 16'(16'h0C00 + ilv[i]));
    end
    step();
    chk("ilv_end", dq, 16'hFFFF);

    // Full page across the column wrap, both directions stopped by BURST TERMINATE
    cmd(PRE, 0, 12'h400);
    cmd(LMR, 0, 12'h027);
    cmd(ACT, 1, 12'h055);
    tb_drv = 1'b1; tb_dat = 16'h0D1E;
    cmd(WR, 1, 12'h1FE);
    tb_dat = 16'h0D1F; step();
    tb_dat = 16'h0D00; step();
    tb_dat = 16'h0D01; step();
    tb_dat = 16'h7777;
    cmd(BST, 0, 12'h000);
    tb_drv = 1'b0;
    cmd(RD, 1, 12'h1FE);
    step(); chk("fp_1fe", dq, 16'h0D1E);
    step(); chk("fp_1ff", dq, 16'h0D1F);
    step(); chk("fp_000", dq, 16'h0D00);
    cmd(BST, 0, 12'h000);
    chk("fp_001", dq, 16'h0D01);
    step();
    chk("fp_end", dq, 16'hFFFF);

    // Byte-masked write and read DQM
    cmd(PRE, 0, 12'h400);
    cmd(LMR, 0, 12'h020);
    cmd(ACT, 1, 12'h055);
    tb_drv = 1'b1; tb_dat = 16'hFFFF;
    cmd(WR, 1, 12'h008);
    tb_dat = 16'h1234; dqm = 2'b10;
    cmd(WR, 1, 12'h008);
    dqm = 2'b00; tb_drv = 1'b0;
    cmd(RD, 1, 12'h008);
    step();
    chk("wr_dqm", dq, 16'hFF34);
    dqm = 2'b11;
    cmd(RD, 1, 12'h008);
    dqm = 2'b00;
    step();
    chk("rd_dqm", dq, 16'hFFFF);
    step();

    // Error latching: first error sticks, refresh still counts
    chk("no_err", 16'(err), 16'h0);
    cmd(RD, 2, 12'h000);
    chk("err_set", 16'(err), 16'h1);
    chk("err_c1", 16'(err_code), 16'h1);
    cmd(ACT, 1, 12'h055);
    chk("err_keep", 16'(err_code), 16'h1);
    cmd(REF, 0, 12'h000);
    chk("ref_cnt", refresh_cnt, 16'h1);
    chk("err_keep2", 16'(err_code), 16'h1);

    // Reset in the middle of a CL3 BL8 read
    cmd(PRE, 0, 12'h400);
    cmd(LMR, 0, 12'h033);
    cmd(ACT, 1, 12'h055);
    cmd(RD, 1, 12'h000);
    step();
    step(); chk("pre_rst_w0", dq, 16'h0D00);
    step(); chk("pre_rst_w1", dq, 16'h0D01);
    rst = 1'b1;
    #1;
    chk("mid_rst_dq", dq, 16'hFFFF);
    chk("mid_rst_mode", 16'(mode_reg), 16'h030);
    chk("mid_rst_err", 16'(err), 16'h0);
    chk("mid_rst_code", 16'(err_code), 16'h0);
    step();
    rst = 1'b0;
    step();
    cmd(ACT, 1, 12'h055);
    cmd(RD, 1, 12'h008);
    step();
    chk("post_rst_early", dq, 16'hFFFF);
    step();
    chk("post_rst_data", dq, 16'hFF34);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
